// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR pseudo-random word generator.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } fsm_e;

   // Fibonacci step: shift towards the MSB, feedback parity enters at bit 0.
   function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
      return {state[30:0], ^(state & taps)};
   endfunction

   // Maximal-length feedback masks for widths 3..32; bit i set taps state[i].
   function automatic logic [31:0] default_taps(input int unsigned width);
      logic [31:0] t;
      case (width)
         3:       t = 32'h0000_0006;
         4:       t = 32'h0000_000C;
         5:       t = 32'h0000_0014;
         6:       t = 32'h0000_0030;
         7:       t = 32'h0000_0060;
         8:       t = 32'h0000_00B8;
         9:       t = 32'h0000_0110;
         10:      t = 32'h0000_0240;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0829;
         13:      t = 32'h0000_100D;
         14:      t = 32'h0000_2015;
         15:      t = 32'h0000_6000;
         16:      t = 32'h0000_D008;
         17:      t = 32'h0001_2000;
         18:      t = 32'h0002_0400;
         19:      t = 32'h0004_0023;
         20:      t = 32'h0009_0000;
         21:      t = 32'h0014_0000;
         22:      t = 32'h0030_0000;
         23:      t = 32'h0042_0000;
         24:      t = 32'h00E1_0000;
         25:      t = 32'h0120_0000;
         26:      t = 32'h0200_0023;
         27:      t = 32'h0400_0013;
         28:      t = 32'h0900_0000;
         29:      t = 32'h1400_0000;
         30:      t = 32'h2000_0029;
         31:      t = 32'h4800_0000;
         32:      t = 32'h8020_0003;
         default: t = 32'h0000_0000;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with seed loading, zero-state recovery and period-wrap detection.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 6,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             shift_i,
   input  logic             seed_load_i,
   input  logic [WIDTH-1:0] seed_in_i,
   output logic             msb_o,
   output logic             abort_o,
   output logic             seed_err_o,
   output logic             lockup_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] last_seed_q, last_seed_d;
   logic [WIDTH-1:0] shifted;
   logic             seed_err_q, seed_err_d;
   logic             lockup_q, lockup_d;
   logic             wrap_q, wrap_d;
   logic             zero_state;

   if (SEED == '0) begin : g_seed_check
      $error("lfsr_core: SEED must be nonzero");
   end

   assign shifted    = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS)));
   assign zero_state = (state_q == '0);

   // A seed load outranks zero-state recovery, which outranks a normal shift.
   always_comb begin
      state_d     = state_q;
      last_seed_d = last_seed_q;
      seed_err_d  = 1'b0;
      lockup_d    = 1'b0;
      wrap_d      = 1'b0;
      if (seed_load_i) begin
         if (seed_in_i == '0) begin
            state_d     = SEED;
            last_seed_d = SEED;
            seed_err_d  = 1'b1;
         end else begin
            state_d     = seed_in_i;
            last_seed_d = seed_in_i;
         end
      end else if (zero_state) begin
         state_d     = SEED;
         last_seed_d = SEED;
         lockup_d    = 1'b1;
      end else if (shift_i) begin
         state_d = shifted;
         wrap_d  = (shifted == last_seed_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= SEED;
         last_seed_q <= SEED;
         seed_err_q  <= 1'b0;
         lockup_q    <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_seed_q <= last_seed_d;
         seed_err_q  <= seed_err_d;
         lockup_q    <= lockup_d;
         wrap_q      <= wrap_d;
      end
   end

   assign msb_o      = state_q[WIDTH-1];
   assign abort_o    = seed_load_i | zero_state;
   assign seed_err_o = seed_err_q;
   assign lockup_o   = lockup_q;
   assign wrap_o     = wrap_q;

endmodule

// File: rtl/lfsr_prng_gen.sv
// Request-driven pseudo-random word generator: collects OUT_W LFSR bits per request.
module lfsr_prng_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 6,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
   parameter int unsigned      OUT_W = 3,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   output logic [OUT_W-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   input  logic             seed_load_i,
   input  logic [WIDTH-1:0] seed_in_i,
   output logic             seed_err_o,
   output logic             lockup_o,
   output logic             wrap_o
);

   localparam int unsigned      CNT_W    = $clog2(OUT_W + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(OUT_W);

   if (WIDTH < 3 || WIDTH > 32) begin : g_width_check
      $error("lfsr_prng_gen: WIDTH must be within 3..32");
   end
   if (OUT_W < 1 || OUT_W > WIDTH) begin : g_outw_check
      $error("lfsr_prng_gen: OUT_W must be within 1..WIDTH");
   end

   fsm_e             fsm_q;
   logic [CNT_W-1:0] cnt_q;
   logic [OUT_W-1:0] capture_q, capture_d;
   logic [OUT_W-1:0] out_data_q;
   logic             out_valid_q;
   logic             req_ready_q;
   logic             shift_en;
   logic             core_msb;
   logic             core_abort;

   assign shift_en = (fsm_q == SHIFT) && (cnt_q != CNT_DONE);

   // The first captured bit travels up to the MSB of the finished word.
   always_comb begin
      capture_d    = capture_q << 1;
      capture_d[0] = core_msb;
   end

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_core (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .shift_i     (shift_en),
      .seed_load_i (seed_load_i),
      .seed_in_i   (seed_in_i),
      .msb_o       (core_msb),
      .abort_o     (core_abort),
      .seed_err_o  (seed_err_o),
      .lockup_o    (lockup_o),
      .wrap_o      (wrap_o)
   );

   // The cycle after the last shift publishes the word, so valid lags acceptance by OUT_W+1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q       <= IDLE;
         cnt_q       <= '0;
         capture_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
      end else if (core_abort) begin
         fsm_q       <= IDLE;
         cnt_q       <= '0;
         capture_q   <= '0;
         out_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (req_valid_i) begin
                  fsm_q       <= SHIFT;
                  cnt_q       <= '0;
                  capture_q   <= '0;
                  req_ready_q <= 1'b0;
               end
            end
            SHIFT: begin
               if (cnt_q != CNT_DONE) begin
                  cnt_q     <= cnt_q + 1'b1;
                  capture_q <= capture_d;
               end else begin
                  fsm_q       <= HOLD;
                  out_data_q  <= capture_q;
                  out_valid_q <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready_i) begin
                  fsm_q       <= IDLE;
                  out_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               fsm_q       <= IDLE;
               out_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: doc/lfsr_prng_gen.md
Name: lfsr_prng_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random generator. It produces OUT_W-bit random words on request through a valid/ready handshake. It adds run-time seed loading, zero-seed and lock-up protection, and a period-wrap indicator. It sits between the video test-pattern and noise logic and any consumer that needs random words, and it replaces fixed-width, free-running generators.

Parameters:
WIDTH, 6, LFSR state width in bits (3..32).
TAPS, 6'b110000, feedback mask of WIDTH bits. Bit i set means state[i] is XORed into the feedback. The default gives x^6+x^5+1, period 63.
OUT_W, 3, bits per output word (1..WIDTH).
SEED, 1, reset and fallback seed, WIDTH bits. Must be nonzero (elaboration-time assertion).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-low.
req_valid  in  1  consumer requests a new word.
req_ready  out  1  generator can accept a request.
out_data  out  OUT_W  generated word.
out_valid  out  1  out_data is valid.
out_ready  in  1  consumer accepts out_data.
seed_load  in  1  one-cycle strobe that loads seed_in.
seed_in  in  WIDTH  seed value.
seed_err  out  1  one-cycle pulse: seed_in was zero and SEED was substituted.
lockup  out  1  one-cycle pulse: all-zero state detected and SEED reloaded.
wrap  out  1  one-cycle pulse: state returned to the last-loaded seed.

Behaviour:
- Reset is asynchronous, active-low: rst=0 forces the following at once.
  - state=SEED, last_seed=SEED, FSM=IDLE.
  - out_data=0, out_valid=0, req_ready=1, seed_err=0, lockup=0, wrap=0, shift counter=0.
- Shift operation:
  - fb = XOR-reduce(state & TAPS).
  - state <= {state[WIDTH-2:0], fb}.
  - Captured bit = state[WIDTH-1] before the shift, appended LSB-ward: the first captured bit ends up in out_data[OUT_W-1].
- FSM states:
  - IDLE: req_ready=1. req_valid=1 moves to SHIFT with cnt=0.
  - SHIFT: req_ready=0. One shift per cycle. After OUT_W shifts, move to HOLD. out_data and out_valid are registered on that transition, so out_valid rises OUT_W+1 cycles after the accepting edge.
  - HOLD: out_valid=1, out_data stable. out_ready=1 moves to IDLE and clears out_valid on the next edge. A new request is accepted no earlier than the cycle after the handshake; no back-to-back overlap.
- State never advances in IDLE or HOLD.
- Seed load, with priority over everything except reset:
  - seed_load=1 sets state=last_seed=seed_in, or SEED if seed_in==0; the zero case pulses seed_err.
  - Any in-progress SHIFT or HOLD is aborted: FSM=IDLE, out_valid=0, cnt=0.
  - seed_load coincident with a req_valid handshake: the load wins and the request is dropped; req_ready was 1 but the request is not serviced.
- Lock-up guard: if state==0 at any clock edge outside reset (illegal TAPS or an SEU), reload SEED, pulse lockup, abort as for seed_load. seed_load in the same cycle takes precedence and lockup does not pulse.
- Wrap: pulses for one cycle on the edge after a shift whose result equals last_seed. With the default parameters this happens every 63 shifts.
- Width rules:
  - cnt is clog2(OUT_W+1) bits.
  - No arithmetic on state; XOR and shift only.

Decomposition:
- Package lfsr_pkg holds:
  - FSM enum typedef (IDLE, SHIFT, HOLD).
  - Function lfsr_next(state, taps) returning the next state.
  - Constant default tap masks for widths 3..32 (maximal-length).
- Natural sub-module: lfsr_core (state register, feedback, seed/lock-up handling, wrap compare).
- lfsr_prng_gen adds the request FSM and output register.

Test Plan:
1. Reset with defaults, one request, out_ready=1 -> out_valid rises 4 cycles after accept, out_data=3'b000, internal state=6'b001000.
2. Second request -> out_data=3'b001, state=6'b000011.
3. 21 consecutive requests from reset (63 shifts) -> wrap pulses exactly once, on the final shift; state==6'b000001.
4. Request, hold out_ready=0 for 10 cycles -> out_data stable and out_valid held; no state change; on out_ready=1, out_valid clears next cycle.
5. seed_load with seed_in=6'b000000 mid-SHIFT -> seed_err pulses, state=6'b000001, out_valid=0, FSM IDLE; next request returns 3'b000.
6. Force state=0 via hierarchical deposit -> lockup pulses next edge, state=SEED; rst asserted mid-HOLD -> out_valid drops asynchronously.
